// File: rtl/flounder_pkg.sv
// Shared types and constants for the Flounder PS/2 keyboard controller.
package flounder_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_OVF     = 7;
  localparam int ST_PAR_ERR = 6;
  localparam int ST_FRM_ERR = 5;
  localparam int ST_FULL    = 4;

  localparam int CTRL_INT_EN = 0;
  localparam int CTRL_RX_EN  = 1;
  localparam logic [1:0] CTRL_RESET = 2'b10;

  // STATUS only has four count bits, so a 16-deep FIFO reports 15 when full.
  function automatic logic [3:0] sat_count4(input logic [7:0] c);
    return (c > 8'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/flounder_sync_fifo.sv
// Single-clock FIFO with simultaneous push/pop; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module flounder_sync_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic [CW-1:0]    count_next_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  assign dout_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

  // NOTE: non-blocking assignments in every clocked block so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; empty_o gates every read of it.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/flounder_kb_ctrl.sv
// PS/2 keyboard receiver with scan-code FIFO, level IRQ and a strobe-based
// register port (DATA / STATUS / CTRL).
module flounder_kb_ctrl
  import flounder_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SAMPLE_DELAY   = 8,
  parameter int TIMEOUT_CYCLES = 40000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KB_CLK,
  input  logic       KB_DATA,
  input  logic       sel,
  input  logic [1:0] addr,
  input  logic       rd_stb,
  input  logic       wr_stb,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq
);

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int SDW = $clog2(SAMPLE_DELAY + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

  logic kbc_s1_q, kbc_s2_q, kbc_prev_q, kbd_s1_q, kbd_s2_q;
  logic busy_q, busy_d;
  logic [SDW-1:0] dly_q, dly_d;
  logic [TOW-1:0] idle_cnt_q, idle_cnt_d;
  rx_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic par_q, par_d;
  logic ovf_q, ovf_d, par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic irq_q, irq_d;
  logic fall, sample, timeout, rx_en;
  logic push_req, set_ovf, set_par, set_frm;
  logic pop_req, wr_status, wr_ctrl;
  logic [7:0] fifo_head;
  logic fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, fifo_count_next;
  logic unused_wdata;

  assign unused_wdata = ^wdata[4:2];

  assign fall    = kbc_prev_q & ~kbc_s2_q;
  assign sample  = busy_q && (dly_q == SDW'(SAMPLE_DELAY));
  assign timeout = (state_q != RX_IDLE) && (idle_cnt_q == TOW'(TIMEOUT_CYCLES));
  assign rx_en   = ctrl_q[CTRL_RX_EN];

  // A new falling edge always restarts the sample countdown.
  always_comb begin
    busy_d = busy_q;
    dly_d  = dly_q;
    if (fall) begin
      busy_d = 1'b1;
      dly_d  = SDW'(1);
    end else if (sample) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      dly_d = dly_q + SDW'(1);
    end
    idle_cnt_d = (state_q == RX_IDLE || fall) ? '0 : idle_cnt_q + TOW'(1);
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    push_req  = 1'b0;
    set_par   = 1'b0;
    set_frm   = 1'b0;
    if (!rx_en) begin
      state_d = RX_IDLE;
    end else if (timeout) begin
      state_d = RX_IDLE;
      set_frm = 1'b1;
    end else if (sample) begin
      unique case (state_q)
        RX_IDLE: begin
          if (!kbd_s2_q) begin
            state_d   = RX_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            set_frm = 1'b1;
          end
        end
        RX_DATA: begin
          shift_d   = {kbd_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = kbd_s2_q;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          if (!kbd_s2_q)              set_frm  = 1'b1;
          else if (^{shift_q, par_q}) push_req = 1'b1;
          else                        set_par  = 1'b1;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  assign pop_req   = sel & rd_stb & (addr == REG_DATA);
  assign wr_status = sel & wr_stb & (addr == REG_STATUS);
  assign wr_ctrl   = sel & wr_stb & (addr == REG_CTRL);
  // A full FIFO still takes the byte when a pop frees a slot in that cycle.
  assign set_ovf   = push_req & fifo_full & ~pop_req;

  always_comb begin
    ovf_d     = set_ovf | (ovf_q     & ~(wr_status & wdata[ST_OVF]));
    par_err_d = set_par | (par_err_q & ~(wr_status & wdata[ST_PAR_ERR]));
    frm_err_d = set_frm | (frm_err_q & ~(wr_status & wdata[ST_FRM_ERR]));
    ctrl_d    = wr_ctrl ? wdata[1:0] : ctrl_q;
    irq_d     = ctrl_d[CTRL_INT_EN] & (fifo_count_next != '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      kbc_s1_q   <= 1'b1;
      kbc_s2_q   <= 1'b1;
      kbc_prev_q <= 1'b1;
      kbd_s1_q   <= 1'b1;
      kbd_s2_q   <= 1'b1;
      busy_q     <= 1'b0;
      dly_q      <= '0;
      idle_cnt_q <= '0;
      state_q    <= RX_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      ovf_q      <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      ctrl_q     <= CTRL_RESET;
      irq_q      <= 1'b0;
    end else begin
      kbc_s1_q   <= KB_CLK;
      kbc_s2_q   <= kbc_s1_q;
      kbc_prev_q <= kbc_s2_q;
      kbd_s1_q   <= KB_DATA;
      kbd_s2_q   <= kbd_s1_q;
      busy_q     <= busy_d;
      dly_q      <= dly_d;
      idle_cnt_q <= idle_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ovf_q      <= ovf_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      ctrl_q     <= ctrl_d;
      irq_q      <= irq_d;
    end
  end

  flounder_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk_i        (CLK),
    .rst_i        (RST),
    .push_i       (push_req),
    .din_i        (shift_q),
    .pop_i        (pop_req),
    .dout_o       (fifo_head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count),
    .count_next_o (fifo_count_next)
  );

  always_comb begin
    unique case (addr)
      REG_DATA:   rdata = fifo_empty ? 8'h00 : fifo_head;
      REG_STATUS: rdata = {ovf_q, par_err_q, frm_err_q, fifo_full,
                           sat_count4(8'(fifo_count))};
      REG_CTRL:   rdata = {6'b0, ctrl_q};
      default:    rdata = 8'h00;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_flounder_kb_ctrl.sv
// Self-checking bench: register-port vector table, then PS/2 frame sequences
// covering parity, overflow, timeout, full push+pop and mid-frame reset.
module tb_flounder_kb_ctrl;

  localparam int H       = 20;     // CLK cycles per PS/2 clock half-period
  localparam int TIMEOUT = 40000;

  logic CLK = 1'b0;
  logic RST, KB_CLK, KB_DATA, sel, rd_stb, wr_stb, irq;
  logic [1:0] addr;
  logic [7:0] wdata, rdata, q;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       sel;
    logic [1:0] addr;
    logic       wr;
    logic       rd;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[14];

  always #5 CLK = ~CLK;

  flounder_kb_ctrl #(.FIFO_DEPTH(8), .SAMPLE_DELAY(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .KB_CLK  (KB_CLK),
    .KB_DATA (KB_DATA),
    .sel     (sel),
    .addr    (addr),
    .rd_stb  (rd_stb),
    .wr_stb  (wr_stb),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check_irq(input string name, input logic exp);
    check(name, {7'd0, irq}, {7'd0, exp});
  endtask

  // One bus cycle; q is rdata seen during the access, before the edge acts.
  task automatic access(input logic s, input logic [1:0] a, input logic w,
                        input logic r, input logic [7:0] d, output logic [7:0] qo);
    @(negedge CLK);
    sel = s; addr = a; wr_stb = w; rd_stb = r; wdata = d;
    #1 qo = rdata;
    @(negedge CLK);
    sel = 1'b0; wr_stb = 1'b0; rd_stb = 1'b0;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    access(1'b1, a, 1'b1, 1'b0, d, dummy);
  endtask

  task automatic peek_check(input string name, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] v;
    access(1'b1, a, 1'b0, 1'b0, 8'h00, v);
    check(name, v, exp);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    logic [7:0] v;
    access(1'b1, 2'd0, 1'b0, 1'b1, 8'h00, v);
    check(name, v, exp);
  endtask

  // Sends the first nbits of an 11-bit frame; optionally pulses a DATA pop in
  // the cycle the stop-bit sample lands (2 sync + 1 edge + SAMPLE_DELAY).
  task automatic send_frame(input logic [7:0] d, input logic par, input int nbits,
                            input bit pop_at_stop);
    logic [10:0] f;
    f = {1'b1, par, d, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      @(negedge CLK);
      KB_DATA = f[b];
      repeat (H - 1) @(negedge CLK);
      KB_CLK = 1'b0;
      for (int i = 1; i <= H; i++) begin
        @(negedge CLK);
        if (pop_at_stop && b == 10) begin
          sel = (i == 10); addr = 2'd0; rd_stb = (i == 10);
        end
      end
      KB_CLK = 1'b1;
    end
    @(negedge CLK);
    KB_DATA = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  initial begin
    RST = 1'b1; KB_CLK = 1'b1; KB_DATA = 1'b1;
    sel = 1'b0; addr = 2'd0; rd_stb = 1'b0; wr_stb = 1'b0; wdata = 8'h00;

    //             sel   addr  wr    rd    wdata  exp    irq
    vecs[0]  = '{1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 2'd3, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 2'd2, 1'b1, 1'b0, 8'hFF, 8'h02, 1'b0};
    vecs[5]  = '{1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0};
    vecs[6]  = '{1'b0, 2'd2, 1'b1, 1'b0, 8'h00, 8'h03, 1'b0};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0};
    vecs[8]  = '{1'b1, 2'd3, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0};
    vecs[9]  = '{1'b1, 2'd0, 1'b1, 1'b0, 8'h55, 8'h00, 1'b0};
    vecs[10] = '{1'b1, 2'd1, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0};
    vecs[11] = '{1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[12] = '{1'b1, 2'd2, 1'b1, 1'b0, 8'h02, 8'h03, 1'b0};
    vecs[13] = '{1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0};

    repeat (4) @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      sel = vecs[i].sel; addr = vecs[i].addr; wr_stb = vecs[i].wr;
      rd_stb = vecs[i].rd; wdata = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check_irq($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
      @(negedge CLK);
      sel = 1'b0; wr_stb = 1'b0; rd_stb = 1'b0;
    end

    // 0x1C: IRQ only once int_en is set, drops the cycle after the pop.
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    peek_check("t1_status", 2'd1, 8'h01);
    check_irq("t1_irq_masked", 1'b0);
    reg_wr(2'd2, 8'h03);
    check_irq("t1_irq_enabled", 1'b1);
    pop_check("t1_data", 8'h1C);
    check_irq("t1_irq_after_pop", 1'b0);
    peek_check("t1_status_empty", 2'd1, 8'h00);

    // 0xF0 with a wrong parity bit, then W1C.
    send_frame(8'hF0, 1'b0, 11, 1'b0);
    peek_check("t2_status", 2'd1, 8'h40);
    check_irq("t2_irq", 1'b0);
    reg_wr(2'd1, 8'h40);
    peek_check("t2_status_clr", 2'd1, 8'h00);

    // Nine frames into an 8-deep FIFO.
    for (int k = 1; k <= 9; k++) send_frame(8'(k), odd_par(8'(k)), 11, 1'b0);
    peek_check("t3_status", 2'd1, 8'h98);
    check_irq("t3_irq", 1'b1);
    for (int k = 1; k <= 8; k++) pop_check($sformatf("t3_data%0d", k), 8'(k));
    pop_check("t3_data_empty", 8'h00);
    check_irq("t3_irq_empty", 1'b0);
    reg_wr(2'd1, 8'hE0);
    peek_check("t3_status_clr", 2'd1, 8'h00);

    // Frame abandoned after four data bits, then a clean 0x5A.
    send_frame(8'h0F, 1'b0, 5, 1'b0);
    repeat (100) @(negedge CLK);
    peek_check("t4_before_timeout", 2'd1, 8'h00);
    repeat (TIMEOUT) @(negedge CLK);
    peek_check("t4_timeout", 2'd1, 8'h20);
    send_frame(8'h5A, odd_par(8'h5A), 11, 1'b0);
    peek_check("t4_status_next", 2'd1, 8'h21);
    pop_check("t4_data", 8'h5A);
    reg_wr(2'd1, 8'h20);
    peek_check("t4_status_clr", 2'd1, 8'h00);

    // Full FIFO, pop lands in the same cycle as the 0x33 push.
    for (int k = 0; k < 8; k++) send_frame(8'h11 + 8'(k), odd_par(8'h11 + 8'(k)), 11, 1'b0);
    peek_check("t5_status_full", 2'd1, 8'h18);
    send_frame(8'h33, odd_par(8'h33), 11, 1'b1);
    peek_check("t5_status_after", 2'd1, 8'h18);
    for (int k = 0; k < 7; k++) pop_check($sformatf("t5_data%0d", k), 8'h12 + 8'(k));
    pop_check("t5_last", 8'h33);
    peek_check("t5_status_empty", 2'd1, 8'h00);

    // Receiver disabled: frame ignored, no flags.
    reg_wr(2'd2, 8'h01);
    send_frame(8'h44, odd_par(8'h44), 11, 1'b0);
    peek_check("t6_rx_off_status", 2'd1, 8'h00);
    check_irq("t6_rx_off_irq", 1'b0);
    reg_wr(2'd2, 8'h03);

    // Reset in the middle of a frame with state and flags pending.
    send_frame(8'h77, odd_par(8'h77), 11, 1'b0);
    send_frame(8'h10, ~odd_par(8'h10), 11, 1'b0);
    peek_check("t7_pre_status", 2'd1, 8'h41);
    check_irq("t7_pre_irq", 1'b1);
    send_frame(8'hFF, 1'b1, 5, 1'b0);
    @(negedge CLK); RST = 1'b1;
    repeat (2) @(negedge CLK); RST = 1'b0;
    peek_check("t7_status", 2'd1, 8'h00);
    peek_check("t7_ctrl", 2'd2, 8'h02);
    peek_check("t7_data", 2'd0, 8'h00);
    check_irq("t7_irq", 1'b0);
    send_frame(8'hA5, odd_par(8'hA5), 11, 1'b0);
    peek_check("t7_status_next", 2'd1, 8'h01);
    pop_check("t7_data_next", 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
